// File: rtl/fifo_port_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_sel_pkg
// Description : Shared constants, helpers and types for the per-FIFO
//               round-robin arbiter of the bus-select fabric.
//               - PORT_NUM_DEF : default number of fd sources
//               - idx_w()      : width of a binary source index
//               - arb_state_t  : arbiter FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package bus_sel_pkg;

    localparam int PORT_NUM_DEF = 6;

    // Binary index width for an n-entry vector. The result is never below 1,
    // so that a single-source build still has a legal index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_port_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_port_rr_arbiter_if
// Description : Handshake bundle between the fd sources / FIFO and one
//               per-FIFO arbiter.
//               req        : fifo_y_bus_sel, bit x = fd_x requests this FIFO
//               src_valid  : bit x = fd_x presents a beat
//               src_last   : bit x = fd_x beat is last of its packet
//               fifo_full  : FIFO cannot accept a beat this cycle
//               src_ready  : per-source ready back to the fd sources
//               fifo_wr_en : FIFO write enable (beat accepted)
//               modport master : source / FIFO side
//               modport slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_port_rr_arbiter_if
    import bus_sel_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUM_DEF
);
    logic [PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0] src_valid;
    logic [PORT_NUM-1:0] src_last;
    logic                fifo_full;
    logic [PORT_NUM-1:0] src_ready;
    logic                fifo_wr_en;

    modport master (
        output req,
        output src_valid,
        output src_last,
        output fifo_full,
        input  src_ready,
        input  fifo_wr_en
    );

    modport slave (
        input  req,
        input  src_valid,
        input  src_last,
        input  fifo_full,
        output src_ready,
        output fifo_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/fifo_port_rr_arbiter_rr_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_pick
// Description : Combinational round-robin selector. Returns the first set
//               request bit at an index >= ptr, wrapping modulo PORT_NUM.
//               req    : request vector
//               ptr    : search start index
//               onehot : one-hot of the chosen source (zero when none)
//               idx    : binary index of the chosen source (zero when none)
//               any    : at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_pick
    import bus_sel_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUM_DEF,
    parameter int IDX_W    = idx_w(PORT_NUM)
) (
    input  wire logic [PORT_NUM-1:0] req,
    input  wire logic [IDX_W-1:0]    ptr,
    output logic      [PORT_NUM-1:0] onehot,
    output logic      [IDX_W-1:0]    idx,
    output logic                     any
);

    localparam int POS_W = idx_w(2 * PORT_NUM);

    logic [PORT_NUM-1:0]   w_mask;
    logic [2*PORT_NUM-1:0] w_dbl;
    logic [POS_W-1:0]      w_pos;

    // Double-width trick: the low half holds only requests at or above ptr,
    // the high half holds every request. The lowest set bit of the
    // concatenation is therefore the wrapped round-robin winner.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
        w_dbl = {req, req & w_mask};

        w_pos = '0;
        for (int i = 2 * PORT_NUM - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_pos = POS_W'(i);
            end
        end

        if (int'(w_pos) >= PORT_NUM) begin
            idx = IDX_W'(int'(w_pos) - PORT_NUM);
        end else begin
            idx = IDX_W'(w_pos);
        end

        any    = |req;
        onehot = any ? ({{(PORT_NUM-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_port_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_port_rr_arbiter
// Description : Per-FIFO packet arbiter. Grants one fd source at a time in
//               round-robin order and holds the grant until the last beat
//               of the packet, an abort (req dropped) or a stall timeout.
//               clk         : clock, rising edge
//               rst         : synchronous active-high reset
//               bus         : handshake bundle (slave modport)
//               grant       : registered one-hot grant, zero when idle
//               grant_idx   : binary index of the granted source, 0 when idle
//               busy        : a grant is held
//               err_abort   : 1-cycle pulse, granted source dropped req
//               err_timeout : 1-cycle pulse, grant released by timeout
//               pkt_cnt     : completed packets, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_port_rr_arbiter
    import bus_sel_pkg::*;
#(
    parameter int PORT_NUM    = PORT_NUM_DEF,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = idx_w(PORT_NUM)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    fifo_port_rr_arbiter_if.slave    bus,
    output logic      [PORT_NUM-1:0] grant,
    output logic      [IDX_W-1:0]    grant_idx,
    output logic                     busy,
    output logic                     err_abort,
    output logic                     err_timeout,
    output logic      [CNT_W-1:0]    pkt_cnt
);

    localparam int IC_W = idx_w(TIMEOUT_CYC + 1);

    arb_state_t          state_q,       state_d;
    logic [PORT_NUM-1:0] grant_q,       grant_d;
    logic [IDX_W-1:0]    grant_idx_q,   grant_idx_d;
    logic [IDX_W-1:0]    ptr_q,         ptr_d;
    logic [IC_W-1:0]     idle_cnt_q,    idle_cnt_d;
    logic [CNT_W-1:0]    pkt_cnt_q,     pkt_cnt_d;
    logic                err_abort_q,   err_abort_d;
    logic                err_timeout_q, err_timeout_d;

    logic [PORT_NUM-1:0] w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_beat;
    logic                w_last;
    logic                w_req_held;
    logic                w_timeout;
    logic [IDX_W-1:0]    w_ptr_next;

    rr_prio_pick #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // grant_q is zero in IDLE, so the beat term needs no extra state gating.
    assign w_beat     = (|(grant_q & bus.src_valid)) & ~bus.fifo_full;
    assign w_last     = w_beat & bus.src_last[grant_idx_q];
    assign w_req_held = bus.req[grant_idx_q];
    // A full FIFO stalls the count, so it can only expire on a free cycle.
    assign w_timeout  = (idle_cnt_q == IC_W'(TIMEOUT_CYC - 1)) & ~w_beat & ~bus.fifo_full;
    assign w_ptr_next = (grant_idx_q == IDX_W'(PORT_NUM - 1)) ? '0 : grant_idx_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        idle_cnt_d    = idle_cnt_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_abort_d   = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    state_d     = BUSY;
                    grant_d     = w_pick_onehot;
                    grant_idx_d = w_pick_idx;
                    idle_cnt_d  = '0;
                end
            end
            BUSY: begin
                if (w_beat) begin
                    idle_cnt_d = '0;
                end else if (!bus.fifo_full && (idle_cnt_q != '1)) begin
                    idle_cnt_d = idle_cnt_q + IC_W'(1);
                end

                // Release priority: last beat, then abort, then timeout.
                if (w_last || !w_req_held || w_timeout) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                    ptr_d       = w_ptr_next;
                    if (w_last) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end else if (!w_req_held) begin
                        err_abort_d = 1'b1;
                    end else begin
                        err_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            ptr_q         <= '0;
            idle_cnt_q    <= '0;
            pkt_cnt_q     <= '0;
            err_abort_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            ptr_q         <= ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_abort_q   <= err_abort_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.src_ready  = grant_q & {PORT_NUM{~bus.fifo_full}};
    assign bus.fifo_wr_en = w_beat;
    assign grant          = grant_q;
    assign grant_idx      = grant_idx_q;
    assign busy           = (state_q == BUSY);
    assign err_abort      = err_abort_q;
    assign err_timeout    = err_timeout_q;
    assign pkt_cnt        = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_port_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_port_rr_arbiter
// Description : Self-checking bench for fifo_port_rr_arbiter. A transaction
//               level model tracks grant owner, round-robin pointer, stall
//               count and packet count; directed scenarios add literal
//               expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_port_rr_arbiter;
    import bus_sel_pkg::*;

    localparam int N  = 6;
    localparam int TO = 255;
    localparam int CW = 16;
    localparam int IW = idx_w(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_port_rr_arbiter_if #(.PORT_NUM(N)) bus ();

    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          err_abort;
    logic          err_timeout;
    logic [CW-1:0] pkt_cnt;

    fifo_port_rr_arbiter #(
        .PORT_NUM    (N),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .err_abort   (err_abort),
        .err_timeout (err_timeout),
        .pkt_cnt     (pkt_cnt)
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    bit     chk_en   = 1'b0;
    longint cyc      = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_busy;
    int            m_idx;
    int            m_ptr;
    int            m_idle;
    logic [CW-1:0] m_pkt;
    bit            m_ea;
    bit            m_et;

    function automatic int m_rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic bit m_beat();
        return m_busy && bus.src_valid[m_idx] && !bus.fifo_full;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 1'b0; m_idx <= 0; m_ptr <= 0; m_idle <= 0;
            m_pkt  <= '0;   m_ea  <= 1'b0; m_et <= 1'b0;
        end else begin
            m_ea <= 1'b0;
            m_et <= 1'b0;
            if (!m_busy) begin
                if (bus.req != '0) begin
                    m_busy <= 1'b1;
                    m_idx  <= m_rr(bus.req, m_ptr);
                    m_idle <= 0;
                end
            end else begin
                if (m_beat()) m_idle <= 0;
                else if (!bus.fifo_full) m_idle <= m_idle + 1;

                if (m_beat() && bus.src_last[m_idx]) begin
                    m_pkt  <= m_pkt + 1'b1;
                    m_busy <= 1'b0;
                    m_ptr  <= (m_idx + 1) % N;
                end else if (!bus.req[m_idx]) begin
                    m_ea   <= 1'b1;
                    m_busy <= 1'b0;
                    m_ptr  <= (m_idx + 1) % N;
                end else if (m_idle == TO - 1 && !m_beat() && !bus.fifo_full) begin
                    m_et   <= 1'b1;
                    m_busy <= 1'b0;
                    m_ptr  <= (m_idx + 1) % N;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = m_busy ? (N'(1) << m_idx) : '0;
            cmp("grant",       32'(grant),          32'(eg));
            cmp("grant_idx",   32'(grant_idx),      m_busy ? 32'(m_idx) : 32'd0);
            cmp("busy",        32'(busy),           32'(m_busy));
            cmp("err_abort",   32'(err_abort),      32'(m_ea));
            cmp("err_timeout", 32'(err_timeout),    32'(m_et));
            cmp("pkt_cnt",     32'(pkt_cnt),        32'(m_pkt));
            cmp("fifo_wr_en",  32'(bus.fifo_wr_en), 32'(m_beat()));
            cmp("src_ready",   32'(bus.src_ready),  32'(eg & {N{~bus.fifo_full}}));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        n_assert++;
        n_fail++;
        $display("FAIL wait_busy: got no grant within 20 cycles, expected a grant");
    endtask

    task automatic run_pkt(input int nb, input int exp_idx);
        bit ok;
        wait_busy(ok);
        if (!ok) return;
        cmp("grant_order", 32'(grant_idx), 32'(exp_idx));
        for (int b = 0; b < nb; b++) begin
            bus.src_valid = '1;
            bus.src_last  = (b == nb - 1) ? '1 : '0;
            tick();
        end
        bus.src_valid = '0;
        bus.src_last  = '0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bit     ok;
        int     hits;
        longint t0;

        rst           = 1'b1;
        bus.req       = '0;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.fifo_full = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        cmp("reset_grant",   32'(grant),   32'd0);
        cmp("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        cmp("reset_busy",    32'(busy),    32'd0);

        // Round-robin between sources 0 and 2, 2-beat packets.
        bus.req = 6'b000101;
        run_pkt(2, 0);
        run_pkt(2, 2);
        run_pkt(2, 0);
        run_pkt(2, 2);
        cmp("rr_pkt_cnt", 32'(pkt_cnt), 32'd4);

        // Pointer wrap: grant 4, then 5 and 0.
        bus.req = 6'b010000;
        run_pkt(1, 4);
        bus.req = 6'b100001;
        run_pkt(1, 5);
        run_pkt(1, 0);
        cmp("wrap_pkt_cnt", 32'(pkt_cnt), 32'd7);

        // Backpressure on source 3 for 300 cycles.
        bus.req = 6'b001000;
        wait_busy(ok);
        cmp("bp_grant_idx", 32'(grant_idx), 32'd3);
        bus.fifo_full = 1'b1;
        bus.src_valid = '1;
        bus.src_last  = '1;
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.fifo_wr_en || err_timeout) hits++;
        end
        cmp("bp_no_write_no_timeout", 32'(hits), 32'd0);
        cmp("bp_grant_held", 32'(grant), 32'b001000);
        bus.fifo_full = 1'b0;
        #1;
        cmp("bp_beat_written", 32'(bus.fifo_wr_en), 32'd1);
        tick();
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.req       = '0;
        cmp("bp_released", 32'(busy), 32'd0);
        cmp("bp_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // Timeout on source 1.
        bus.req = 6'b000010;
        wait_busy(ok);
        cmp("to_grant_idx", 32'(grant_idx), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err_timeout) break;
        end
        cmp("to_latency", 32'(cyc - t0), 32'd255);
        cmp("to_grant_cleared", 32'(grant), 32'd0);
        cmp("to_pkt_cnt", 32'(pkt_cnt), 32'd8);
        bus.req = '1;
        run_pkt(1, 2);
        bus.req = '0;
        cmp("to_next_pkt_cnt", 32'(pkt_cnt), 32'd9);

        // Abort: source 4 drops req after the first beat.
        bus.req = 6'b010000;
        wait_busy(ok);
        cmp("ab_grant_idx", 32'(grant_idx), 32'd4);
        bus.src_valid = '1;
        bus.src_last  = '0;
        tick();
        bus.req       = '0;
        bus.src_valid = '0;
        tick();
        cmp("ab_err_abort", 32'(err_abort), 32'd1);
        cmp("ab_released", 32'(busy), 32'd0);
        cmp("ab_pkt_cnt", 32'(pkt_cnt), 32'd9);

        // req drops together with an accepted last beat on source 5.
        bus.req = 6'b100000;
        wait_busy(ok);
        cmp("lb_grant_idx", 32'(grant_idx), 32'd5);
        bus.src_valid = '1;
        bus.src_last  = '1;
        bus.req       = '0;
        #1;
        cmp("lb_beat_written", 32'(bus.fifo_wr_en), 32'd1);
        tick();
        bus.src_valid = '0;
        bus.src_last  = '0;
        cmp("lb_no_abort", 32'(err_abort), 32'd0);
        cmp("lb_pkt_cnt", 32'(pkt_cnt), 32'd10);
        cmp("lb_released", 32'(busy), 32'd0);

        // Reset during beat 2 of a packet on source 4.
        bus.req = 6'b010000;
        wait_busy(ok);
        cmp("rs_grant_idx", 32'(grant_idx), 32'd4);
        bus.src_valid = '1;
        bus.src_last  = '0;
        tick();
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.src_valid = '0;
        bus.req       = '1;
        cmp("rs_grant",    32'(grant),       32'd0);
        cmp("rs_pkt_cnt",  32'(pkt_cnt),     32'd0);
        cmp("rs_abort",    32'(err_abort),   32'd0);
        cmp("rs_timeout",  32'(err_timeout), 32'd0);
        run_pkt(1, 0);
        bus.req = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
